axi4_lite_master_ctrl_p: RTL

Parametrised, next-generation AXI4-Lite master that bridges a simple user command interface onto the five AXI4-Lite channels. It adds configurable address and data width, user byte strobes, and independent AW/W handshaking in either order. It also returns BRESP/RRESP to the user with a completion pulse, and has a per-transaction timeout watchdog. Write and read engines run concurrently and sit between user logic and an AXI4-Lite interconnect or slave.

---
 rtl/axi4_lite_master_ctrl_p_pkg.sv | 25 ++
 rtl/axi4_lite_master_ctrl_p_if.sv | 44 ++++
 rtl/axi4_lite_master_ctrl_p_tmo_cnt.sv | 30 +++
 rtl/axi4_lite_master_ctrl_p.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_master_ctrl_p_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes, FSM state
// encodings and a constant-safe clog2.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4_lite_master_ctrl_p_if.sv
// AXI4-Lite five-channel bundle; the master drives AW/W/AR and the ready of B/R.
interface axi4_lite_master_ctrl_p_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi4_lite_master_ctrl_p_tmo_cnt.sv
// Per-engine watchdog: counts busy cycles since accept and flags the last
// allowed cycle so the FSM can abort on the following edge.
module axi4_lite_tmo_cnt
    import axi4_lite_pkg::*;
#(
    parameter int TMO_CYCLES = 1024
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic run,
    output logic expired
);
    localparam int CW = clog2(TMO_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TMO_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TMO_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Saturates at the limit so a long stay can never wrap back under it.
    always_ff @(posedge clk) begin
        if (srst || clr)
            r_cnt <= '0;
        else if (run && (r_cnt != LIMIT))
            r_cnt <= r_cnt + CW'(1);
    end

    assign expired = run && (r_cnt >= LAST);

endmodule

// File: rtl/axi4_lite_master_ctrl_p.sv
// AXI4-Lite master: independent write and read engines bridging a simple
// request/done user interface onto the AXI channels, each with a watchdog.
module axi4_lite_master_ctrl_p
    import axi4_lite_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter int         TMO_CYCLES = 1024,
    parameter logic [2:0] AXI_PROT   = 3'b000,
    localparam int        STRB_W     = DATA_W / 8
) (
    input  logic                clk,
    input  logic                srst,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [STRB_W-1:0]   wr_strb,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic                wr_done,
    output logic [1:0]          wr_resp,
    output logic                wr_tmo,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                rd_valid,
    output logic                rd_ready,
    output logic                rd_done,
    output logic [DATA_W-1:0]   rd_data,
    output logic [1:0]          rd_resp,
    output logic                rd_tmo,
    axi4_lite_master_ctrl_p_if.master m_axi
);
    wr_state_t         r_wr_st, w_wr_nxt;
    rd_state_t         r_rd_st, w_rd_nxt;
    logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
    logic [DATA_W-1:0] r_wr_data, r_rd_data;
    logic [STRB_W-1:0] r_wr_strb;
    logic              r_aw_ok, r_w_ok;
    logic              r_wr_done, r_wr_tmo, r_rd_done, r_rd_tmo;
    logic [1:0]        r_wr_resp, r_rd_resp;
    logic              w_wr_acc, w_rd_acc, w_wr_exp, w_rd_exp;
    logic              w_wr_cmpl, w_wr_abort, w_rd_cmpl, w_rd_abort;
    logic              w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;

    assign wr_ready = (r_wr_st == W_IDLE) && !srst;
    assign rd_ready = (r_rd_st == R_IDLE) && !srst;
    assign w_wr_acc = wr_valid && wr_ready;
    assign w_rd_acc = rd_valid && rd_ready;

    if (TMO_CYCLES > 0) begin : g_tmo
        logic w_wr_run, w_rd_run;
        assign w_wr_run = (r_wr_st != W_IDLE);
        assign w_rd_run = (r_rd_st != R_IDLE);
        axi4_lite_tmo_cnt #(.TMO_CYCLES(TMO_CYCLES)) u_wr_tmo (
            .clk(clk), .srst(srst), .clr(w_wr_acc), .run(w_wr_run), .expired(w_wr_exp));
        axi4_lite_tmo_cnt #(.TMO_CYCLES(TMO_CYCLES)) u_rd_tmo (
            .clk(clk), .srst(srst), .clr(w_rd_acc), .run(w_rd_run), .expired(w_rd_exp));
    end else begin : g_no_tmo
        assign w_wr_exp = 1'b0;
        assign w_rd_exp = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_st <= W_IDLE;
            r_rd_st <= R_IDLE;
        end else begin
            r_wr_st <= w_wr_nxt;
            r_rd_st <= w_rd_nxt;
        end
    end

    // A pending channel's valid is high exactly while its *_ok flag is clear,
    // so a ready seen here is that channel's handshake.
    always_comb begin
        w_wr_nxt   = r_wr_st;
        w_awvalid  = 1'b0;
        w_wvalid   = 1'b0;
        w_bready   = 1'b0;
        w_wr_cmpl  = 1'b0;
        w_wr_abort = 1'b0;
        case (r_wr_st)
            W_IDLE: if (w_wr_acc) w_wr_nxt = W_ADDR_DATA;
            W_ADDR_DATA: begin
                w_awvalid = !r_aw_ok;
                w_wvalid  = !r_w_ok;
                if ((r_aw_ok || m_axi.awready) && (r_w_ok || m_axi.wready)) begin
                    w_wr_nxt = W_RESP;
                end else if (w_wr_exp) begin
                    w_wr_nxt   = W_IDLE;
                    w_wr_abort = 1'b1;
                end
            end
            W_RESP: begin
                w_bready = 1'b1;
                if (m_axi.bvalid) begin
                    w_wr_nxt  = W_IDLE;
                    w_wr_cmpl = 1'b1;
                end else if (w_wr_exp) begin
                    w_wr_nxt   = W_IDLE;
                    w_wr_abort = 1'b1;
                end
            end
            default: w_wr_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rd_nxt   = r_rd_st;
        w_arvalid  = 1'b0;
        w_rready   = 1'b0;
        w_rd_cmpl  = 1'b0;
        w_rd_abort = 1'b0;
        case (r_rd_st)
            R_IDLE: if (w_rd_acc) w_rd_nxt = R_ADDR;
            R_ADDR: begin
                w_arvalid = 1'b1;
                if (m_axi.arready) begin
                    w_rd_nxt = R_DATA;
                end else if (w_rd_exp) begin
                    w_rd_nxt   = R_IDLE;
                    w_rd_abort = 1'b1;
                end
            end
            R_DATA: begin
                w_rready = 1'b1;
                if (m_axi.rvalid) begin
                    w_rd_nxt  = R_IDLE;
                    w_rd_cmpl = 1'b1;
                end else if (w_rd_exp) begin
                    w_rd_nxt   = R_IDLE;
                    w_rd_abort = 1'b1;
                end
            end
            default: w_rd_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_strb <= '0;
            r_aw_ok   <= 1'b0;
            r_w_ok    <= 1'b0;
            r_wr_done <= 1'b0;
            r_wr_resp <= RESP_OKAY;
            r_wr_tmo  <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            if (w_wr_acc) begin
                r_wr_addr <= wr_addr;
                r_wr_data <= wr_data;
                r_wr_strb <= wr_strb;
                r_aw_ok   <= 1'b0;
                r_w_ok    <= 1'b0;
            end
            if (r_wr_st == W_ADDR_DATA) begin
                r_aw_ok <= r_aw_ok || m_axi.awready;
                r_w_ok  <= r_w_ok || m_axi.wready;
            end
            if (w_wr_cmpl) begin
                r_wr_done <= 1'b1;
                r_wr_resp <= m_axi.bresp;
                r_wr_tmo  <= 1'b0;
            end
            if (w_wr_abort) begin
                r_wr_done <= 1'b1;
                r_wr_resp <= RESP_SLVERR;
                r_wr_tmo  <= 1'b1;
            end
        end
    end

    // rd_data is only refreshed by a real R beat, never by an abort.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_rd_done <= 1'b0;
            r_rd_resp <= RESP_OKAY;
            r_rd_tmo  <= 1'b0;
        end else begin
            r_rd_done <= 1'b0;
            if (w_rd_acc) r_rd_addr <= rd_addr;
            if (w_rd_cmpl) begin
                r_rd_done <= 1'b1;
                r_rd_data <= m_axi.rdata;
                r_rd_resp <= m_axi.rresp;
                r_rd_tmo  <= 1'b0;
            end
            if (w_rd_abort) begin
                r_rd_done <= 1'b1;
                r_rd_resp <= RESP_SLVERR;
                r_rd_tmo  <= 1'b1;
            end
        end
    end

    assign m_axi.awaddr  = r_wr_addr;
    assign m_axi.awprot  = AXI_PROT;
    assign m_axi.awvalid = w_awvalid;
    assign m_axi.wdata   = r_wr_data;
    assign m_axi.wstrb   = r_wr_strb;
    assign m_axi.wvalid  = w_wvalid;
    assign m_axi.bready  = w_bready;
    assign m_axi.araddr  = r_rd_addr;
    assign m_axi.arprot  = AXI_PROT;
    assign m_axi.arvalid = w_arvalid;
    assign m_axi.rready  = w_rready;

    assign wr_done = r_wr_done;
    assign wr_resp = r_wr_resp;
    assign wr_tmo  = r_wr_tmo;
    assign rd_done = r_rd_done;
    assign rd_data = r_rd_data;
    assign rd_resp = r_rd_resp;
    assign rd_tmo  = r_rd_tmo;

endmodule
